// File: rtl/knn_vote_pkg.sv
// knn_vote_pkg: FSM state encoding and width helpers shared by the vote classifier files
package knn_vote_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SCAN, ST_DONE} state_e;

    // Bits needed to hold a vote count of 0..k
    function automatic int cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

    // Bits needed to hold an arrival index of 0..k-1 (at least one)
    function automatic int idx_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/knn_vote_if.sv
// knn_vote_if: control, neighbour-label and result handshakes of the vote classifier
interface knn_vote_if #(
    parameter int LABEL_W = 4
);
    logic               start;
    logic               busy;
    logic               nb_valid;
    logic               nb_ready;
    logic [LABEL_W-1:0] nb_label;
    logic               result_valid;
    logic               result_ready;
    logic [LABEL_W-1:0] result_label;

    modport master (
        output start, nb_valid, nb_label, result_ready,
        input  busy, nb_ready, result_valid, result_label
    );

    modport slave (
        input  start, nb_valid, nb_label, result_ready,
        output busy, nb_ready, result_valid, result_label
    );
endinterface

// File: rtl/knn_vote_bank.sv
// knn_vote_bank: per-class vote counters and first-arrival indices with clear, increment and scan read port
module knn_vote_bank #(
    parameter int NCLASS  = 10,
    parameter int LABEL_W = 4,
    parameter int CNT_W   = 3,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [LABEL_W-1:0] label,
    input  logic [IDX_W-1:0]   idx,
    input  logic [LABEL_W-1:0] sel,
    output logic [CNT_W-1:0]   cnt_rd,
    output logic [IDX_W-1:0]   first_rd
);
    logic [CNT_W-1:0] count_q [NCLASS];
    logic [CNT_W-1:0] count_d [NCLASS];
    logic [IDX_W-1:0] first_q [NCLASS];
    logic [IDX_W-1:0] first_d [NCLASS];

    // Clear all classes on a new classification, else count the voted class and note its first arrival
    always_comb begin
        count_d = count_q;
        first_d = first_q;
        for (int i = 0; i < NCLASS; i++) begin
            if (clr) begin
                count_d[i] = '0;
                first_d[i] = '1;
            end else if (inc && label == LABEL_W'(i)) begin
                count_d[i] = count_q[i] + 1'b1;
                if (count_q[i] == '0) first_d[i] = idx;
            end
        end
    end

    // Read the class currently being scanned
    always_comb begin
        cnt_rd   = '0;
        first_rd = '0;
        for (int i = 0; i < NCLASS; i++) begin
            if (sel == LABEL_W'(i)) begin
                cnt_rd   = count_q[i];
                first_rd = first_q[i];
            end
        end
    end

    // Counter and index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '{default: '0};
            first_q <= '{default: '0};
        end else begin
            count_q <= count_d;
            first_q <= first_d;
        end
    end
endmodule

// File: rtl/knn_vote.sv
// knn_vote: majority vote over K nearest-first neighbour labels; ties go to the class seen nearest.
// Define KNN_VOTE_CNT_EN to add the result_votes output carrying the winner's vote count.
module knn_vote
    import knn_vote_pkg::*;
#(
    parameter int K       = 4,
    parameter int NCLASS  = 10,
    parameter int LABEL_W = 4,
    localparam int CNT_W  = cnt_w(K),
    localparam int IDX_W  = idx_w(K)
) (
    input  logic             clk,
    input  logic             rst,
    knn_vote_if.slave        bus
`ifdef KNN_VOTE_CNT_EN
    ,
    output logic [CNT_W-1:0] result_votes
`endif
);
    localparam logic [LABEL_W-1:0] NOVOTE = LABEL_W'(NCLASS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LABEL_W-1:0] c_q, c_d;
    logic [LABEL_W-1:0] best_label_q, best_label_d;
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic               clr, inc, hs, better;
    logic [CNT_W-1:0]   cnt_rd;
    logic [IDX_W-1:0]   first_rd;

    knn_vote_bank #(
        .NCLASS (NCLASS),
        .LABEL_W(LABEL_W),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .inc     (inc),
        .label   (bus.nb_label),
        .idx     (idx_q),
        .sel     (c_q),
        .cnt_rd  (cnt_rd),
        .first_rd(first_rd)
    );

    assign hs     = bus.nb_valid && state_q == ST_ACCUM;
    assign better = (cnt_rd > best_cnt_q) ||
                    (cnt_rd == best_cnt_q && cnt_rd != '0 && first_rd < best_idx_q);

    // Next state, vote bookkeeping and running-best update
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        c_d          = c_q;
        best_label_d = best_label_q;
        best_cnt_d   = best_cnt_q;
        best_idx_d   = best_idx_q;
        clr          = 1'b0;
        inc          = 1'b0;
        unique case (state_q)
            ST_IDLE: if (bus.start) begin
                state_d      = ST_ACCUM;
                clr          = 1'b1;
                idx_d        = '0;
                c_d          = '0;
                best_label_d = NOVOTE;
                best_cnt_d   = '0;
                best_idx_d   = '1;
            end
            ST_ACCUM: if (hs) begin
                inc   = bus.nb_label < NOVOTE;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(K - 1)) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (better) begin
                    best_label_d = c_q;
                    best_cnt_d   = cnt_rd;
                    best_idx_d   = first_rd;
                end
                c_d = c_q + 1'b1;
                if (c_q == LABEL_W'(NCLASS - 1)) state_d = ST_DONE;
            end
            ST_DONE: if (bus.result_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and best-tracker registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            c_q          <= '0;
            best_label_q <= '0;
            best_cnt_q   <= '0;
            best_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            c_q          <= c_d;
            best_label_q <= best_label_d;
            best_cnt_q   <= best_cnt_d;
            best_idx_q   <= best_idx_d;
        end
    end

    assign bus.busy         = state_q != ST_IDLE;
    assign bus.nb_ready     = state_q == ST_ACCUM;
    assign bus.result_valid = state_q == ST_DONE;
    assign bus.result_label = best_label_q;
`ifdef KNN_VOTE_CNT_EN
    assign result_votes     = best_cnt_q;
`endif
endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: table-driven, hand-sequenced and randomized checks of knn_vote against a reference model
module tb_knn_vote;
    localparam int K       = 4;
    localparam int NCLASS  = 10;
    localparam int LABEL_W = 4;
    localparam int CNT_W   = $clog2(K + 1);

    typedef logic [K-1:0][LABEL_W-1:0] lab_t;
    typedef struct {
        lab_t  labs;
        int    exp_label;
        int    exp_votes;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
`ifdef KNN_VOTE_CNT_EN
    logic [CNT_W-1:0] result_votes;
`endif

    knn_vote_if #(.LABEL_W(LABEL_W)) bus ();

    knn_vote #(.K(K), .NCLASS(NCLASS), .LABEL_W(LABEL_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef KNN_VOTE_CNT_EN
        , .result_votes(result_votes)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic lab_t mk(input int a, input int b, input int c, input int d);
        lab_t r;
        r[0] = LABEL_W'(a);
        r[1] = LABEL_W'(b);
        r[2] = LABEL_W'(c);
        r[3] = LABEL_W'(d);
        return r;
    endfunction

    // Winner = nearest in-range label among those holding the maximum vote count
    function automatic void model(input lab_t labs, output int lab, output int votes);
        int cnt[NCLASS];
        int mx = 0;
        foreach (cnt[c]) cnt[c] = 0;
        for (int i = 0; i < K; i++) if (int'(labs[i]) < NCLASS) cnt[labs[i]]++;
        foreach (cnt[c]) if (cnt[c] > mx) mx = cnt[c];
        lab   = NCLASS;
        votes = mx;
        for (int i = K - 1; i >= 0; i--)
            if (int'(labs[i]) < NCLASS && cnt[labs[i]] == mx) lab = int'(labs[i]);
    endfunction

    // One classification: start, feed K labels, check latency and result; optionally leave it in DONE
    task automatic classify(input lab_t labs, input int exp_label, input int exp_votes,
                            input string name, input bit gaps, input bit hold);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, "_busy"}, int'(bus.busy), 1);
        for (int i = 0; i < K; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.nb_valid = 1'b1;
            bus.nb_label = labs[i];
            n = 0;
            while (!bus.nb_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) chk({name, "_hs_timeout"}, 0, 1);
            @(negedge clk);
            bus.nb_valid = 1'b0;
        end
        n = 1;
        while (!bus.result_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, NCLASS + 1);
        chk({name, "_label"}, int'(bus.result_label), exp_label);
`ifdef KNN_VOTE_CNT_EN
        chk({name, "_votes"}, int'(result_votes), exp_votes);
`else
        if (exp_votes < 0) chk({name, "_votes_arg"}, exp_votes, 0);
`endif
        if (!hold) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk({name, "_held"}, int'(bus.result_valid), 1);
            end
            bus.result_ready = 1'b1;
            @(negedge clk);
            bus.result_ready = 1'b0;
            chk({name, "_idle"}, int'(bus.busy), 0);
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   el, ev;
        lab_t r;
        vecs[0] = '{mk(3, 3, 5, 7),     3,  2, "majority"};
        vecs[1] = '{mk(5, 2, 2, 5),     5,  2, "tie_nearest"};
        vecs[2] = '{mk(9, 1, 4, 6),     9,  1, "distinct"};
        vecs[3] = '{mk(12, 12, 12, 4),  4,  1, "drop_oor"};
        vecs[4] = '{mk(12, 12, 12, 12), 10, 0, "sentinel"};
        bus.start        = 1'b0;
        bus.nb_valid     = 1'b0;
        bus.nb_label     = '0;
        bus.result_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_nb_ready", int'(bus.nb_ready), 0);
        chk("rst_valid", int'(bus.result_valid), 0);
        chk("rst_label", int'(bus.result_label), 0);
`ifdef KNN_VOTE_CNT_EN
        chk("rst_votes", int'(result_votes), 0);
`endif
        rst = 1'b1;

        foreach (vecs[v]) classify(vecs[v].labs, vecs[v].exp_label, vecs[v].exp_votes, vecs[v].name, 1'b0, 1'b0);

        // Result held in DONE while start and nb_valid are driven
        classify(mk(3, 3, 5, 7), 3, 2, "hold", 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.start    = (i % 2) == 0;
            bus.nb_valid = 1'b1;
            bus.nb_label = 4'd6;
            @(negedge clk);
            chk("hold_valid", int'(bus.result_valid), 1);
            chk("hold_label", int'(bus.result_label), 3);
            chk("hold_nb_ready", int'(bus.nb_ready), 0);
        end
        bus.nb_valid     = 1'b0;
        bus.start        = 1'b1;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        chk("done_start_ignored", int'(bus.busy), 0);
        chk("done_valid_drop", int'(bus.result_valid), 0);
        classify(mk(9, 1, 4, 6), 9, 1, "after_hold", 1'b0, 1'b0);

        // Reset mid-accumulation discards partial votes
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.nb_valid = 1'b1;
            bus.nb_label = 4'd8;
            @(negedge clk);
        end
        bus.nb_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_nb_ready", int'(bus.nb_ready), 0);
        chk("midrst_label", int'(bus.result_label), 0);
        @(negedge clk);
        rst = 1'b1;
        classify(mk(1, 1, 8, 8), 1, 2, "post_rst", 1'b0, 1'b0);

        // Randomized runs against the reference model
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < K; i++) r[i] = LABEL_W'($urandom_range(0, 12));
            model(r, el, ev);
            classify(r, el, ev, "rand", 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
